// File: rtl/l2_cache_control_if.sv
// l2_cache_control_if: bus bundle between the L2 control FSM, the L1 arbiter
// (upstream), the L2 datapath and physical memory.
//   mem_read/mem_write/mem_resp : upstream request/completion handshake
//   l2_state / lru_way          : per-way {d_out,hit} status and LRU victim from datapath
//   l2_ctl / data_in_sel        : per-way strobes + load_lru and data source select to datapath
//   pmem_*                      : physical memory line read/write handshake
// master = the side that drives requests/status (arbiter + datapath + memory),
// slave  = the control FSM.
interface l2_cache_control_if;
    localparam int unsigned STATE_W = 16;
    localparam int unsigned CTL_W   = 41;
    localparam int unsigned WAY_W   = 3;

    logic               mem_read;
    logic               mem_write;
    logic               mem_resp;
    logic [STATE_W-1:0] l2_state;
    logic [WAY_W-1:0]   lru_way;
    logic [CTL_W-1:0]   l2_ctl;
    logic               data_in_sel;
    logic               pmem_addr_sel;
    logic               pmem_read;
    logic               pmem_write;
    logic               pmem_resp;

    modport master (
        output mem_read, mem_write, l2_state, lru_way, pmem_resp,
        input  mem_resp, l2_ctl, data_in_sel, pmem_addr_sel, pmem_read, pmem_write
    );

    modport slave (
        input  mem_read, mem_write, l2_state, lru_way, pmem_resp,
        output mem_resp, l2_ctl, data_in_sel, pmem_addr_sel, pmem_read, pmem_write
    );
endinterface

// File: rtl/l2_cache_control.sv
// l2_cache_control: control FSM for the 8-way unified L2 cache.
// Serves hits in the request cycle, fills clean misses from physical memory and
// writes back a dirty victim before filling. Keeps saturating hit/miss counters.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : l2_cache_control_if.slave (upstream, datapath and pmem signals)
//   hit_count  : saturating count of hit completions
//   miss_count : saturating count of misses entered
module l2_cache_control #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_cache_control_if.slave    bus,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);
    localparam int unsigned NUM_WAYS = 8;
    localparam int unsigned WAY_W    = 3;
    localparam int unsigned FLD_W    = 5;
    localparam int unsigned CTL_W    = 41;
    localparam int unsigned LRU_BIT  = 40;

    // Way field layout {load_d, load_v, load_TD, d_in, v_in}
    localparam logic [FLD_W-1:0] FLD_WRITE_HIT = 5'b10110;
    localparam logic [FLD_W-1:0] FLD_FILL      = 5'b11101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [NUM_WAYS-1:0] hit_vec;
    logic [NUM_WAYS-1:0] dirty_vec;
    logic [WAY_W-1:0]    hit_way;
    logic                hit_any;
    logic                req;
    logic                hit_inc;
    logic                miss_inc;
    logic                strobe_en;
    logic [WAY_W-1:0]    strobe_way;
    logic [FLD_W-1:0]    strobe_fld;
    logic                load_lru;
    logic [CTL_W-1:0]    ctl;

    // Unpack per-way status; lowest-index hit wins if the datapath reports several
    always_comb begin
        hit_vec   = '0;
        dirty_vec = '0;
        hit_way   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            hit_vec[i]   = bus.l2_state[14 - 2*i];
            dirty_vec[i] = bus.l2_state[15 - 2*i];
        end
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_way = WAY_W'(i);
            end
        end
    end

    assign hit_any = |hit_vec;
    assign req     = bus.mem_read | bus.mem_write;

    // Next-state and combinational outputs
    always_comb begin
        state_d           = state_q;
        bus.mem_resp      = 1'b0;
        bus.data_in_sel   = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        hit_inc           = 1'b0;
        miss_inc          = 1'b0;
        strobe_en         = 1'b0;
        strobe_way        = '0;
        strobe_fld        = '0;
        load_lru          = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit_any) begin
                        bus.mem_resp = 1'b1;
                        load_lru     = 1'b1;
                        hit_inc      = 1'b1;
                        // A write (including read+write together) marks the hit way dirty
                        if (bus.mem_write) begin
                            strobe_en  = 1'b1;
                            strobe_way = hit_way;
                            strobe_fld = FLD_WRITE_HIT;
                        end
                    end else begin
                        miss_inc = 1'b1;
                        state_d  = dirty_vec[bus.lru_way] ? WRITEBACK : FILL;
                    end
                end
            end

            WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                if (bus.pmem_resp) begin
                    state_d = FILL;
                end
            end

            FILL: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    // Install the line into the victim; the held request hits next cycle
                    strobe_en       = 1'b1;
                    strobe_way      = bus.lru_way;
                    strobe_fld      = FLD_FILL;
                    bus.data_in_sel = 1'b1;
                    state_d         = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Saturating counters
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_inc && (hit_cnt_q != {CNT_W{1'b1}})) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if (miss_inc && (miss_cnt_q != {CNT_W{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    // Pack the strobes for the single selected way; way0 occupies the top field
    always_comb begin
        ctl          = '0;
        ctl[LRU_BIT] = load_lru;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (strobe_en && (strobe_way == WAY_W'(i))) begin
                ctl[39 - 5*i -: FLD_W] = strobe_fld;
            end
        end
    end

    assign bus.l2_ctl = ctl;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_l2_cache_control.sv
// Testbench for l2_cache_control: random read/write traffic against a small
// behavioural cache model (one set, 8 ways), plus a reset-during-writeback
// sequence and a CNT_W=2 instance for counter saturation.
module tb_l2_cache_control;
    localparam int NTX = 80;

    logic clk;
    logic rst;

    l2_cache_control_if bus ();
    l2_cache_control_if bus2 ();

    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic [1:0]  hit_count2;
    logic [1:0]  miss_count2;

    l2_cache_control #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    l2_cache_control #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus2.slave),
        .hit_count  (hit_count2),
        .miss_count (miss_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Datapath model: tag store updated only by the strobes the DUT issues
    logic [7:0] dp_tag [8];
    bit         dp_valid [8];
    bit         dp_dirty [8];
    logic [7:0] req_tag;

    always_comb begin
        logic [15:0] st;
        st = '0;
        for (int i = 0; i < 8; i++) begin
            st[15 - 2*i] = dp_dirty[i];
            st[14 - 2*i] = dp_valid[i] && (dp_tag[i] == req_tag);
        end
        bus.l2_state = st;
    end

    // Reference cache contents, advanced by the cache rules at request issue
    logic [7:0] g_tag [8];
    bit         g_valid [8];
    bit         g_dirty [8];

    typedef struct {
        bit         wr;
        bit         miss;
        bit         wb;
        logic [2:0] way;
    } exp_t;

    exp_t exp_q [$];
    int   resp_cnt = 0;
    bit   mon_en   = 1'b0;
    bit   resp_en  = 1'b0;
    int   exp_hits = 0;
    int   exp_misses = 0;

    function automatic logic [40:0] way_ctl(input logic [2:0] way, input logic [4:0] fld, input bit lru);
        logic [40:0] v;
        v = '0;
        v[40] = lru;
        v[39 - 5*int'(way) -: 5] = fld;
        return v;
    endfunction

    // Physical memory: answers a held pmem_read/pmem_write after 1..4 cycles
    initial begin
        int delay;
        delay = 2;
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                if (bus.pmem_resp) begin
                    bus.pmem_resp = 1'b0;
                end else if (bus.pmem_read || bus.pmem_write) begin
                    if (delay == 0) begin
                        bus.pmem_resp = 1'b1;
                        delay = $urandom_range(0, 3);
                    end else begin
                        delay--;
                    end
                end
            end
        end
    end

    // Monitor: checks every cycle against the oldest outstanding expectation
    initial begin
        bit obs_wb;
        bit obs_fill;
        exp_t e;
        obs_wb   = 1'b0;
        obs_fill = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.pmem_write) chk("wb_sel", {62'd0, bus.pmem_read, bus.pmem_addr_sel}, 64'd1);
                if (bus.pmem_read)  chk("fill_sel", {62'd0, bus.pmem_write, bus.pmem_addr_sel}, 64'd0);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    if (bus.pmem_write && bus.pmem_resp) obs_wb = 1'b1;
                    if (bus.pmem_read && bus.pmem_resp) begin
                        obs_fill = 1'b1;
                        chk("wb_before_fill", 64'(obs_wb), 64'(e.wb));
                        chk("fill_ctl", 64'(bus.l2_ctl), 64'(way_ctl(e.way, 5'b11101, 1'b0)));
                        chk("fill_dsel", 64'(bus.data_in_sel), 64'd1);
                    end else if (bus.mem_resp) begin
                        void'(exp_q.pop_front());
                        chk("miss_path", {62'd0, obs_wb, obs_fill}, {62'd0, e.wb, e.miss});
                        chk("resp_ctl", 64'(bus.l2_ctl),
                            64'(way_ctl(e.way, e.wr ? 5'b10110 : 5'b00000, 1'b1)));
                        chk("resp_side", {61'd0, bus.data_in_sel, bus.pmem_read, bus.pmem_write}, 64'd0);
                        obs_wb   = 1'b0;
                        obs_fill = 1'b0;
                        resp_cnt++;
                    end else begin
                        chk("quiet_ctl", 64'(bus.l2_ctl), 64'd0);
                    end
                end else begin
                    chk("idle_quiet", {bus.l2_ctl, bus.mem_resp, bus.data_in_sel, bus.pmem_addr_sel,
                                       bus.pmem_read, bus.pmem_write}, 64'd0);
                end
                // Datapath applies the strobes at the coming edge
                for (int i = 0; i < 8; i++) begin
                    logic [4:0] f;
                    f = bus.l2_ctl[39 - 5*i -: 5];
                    if (f[2]) dp_tag[i]   = req_tag;
                    if (f[3]) dp_valid[i] = f[0];
                    if (f[4]) dp_dirty[i] = f[1];
                end
            end
        end
    end

    initial begin
        int   t;
        bit   wr;
        bit   both;
        int   v;
        int   w;
        bit   hit;
        int   start;
        int   cyc;
        bit   timed_out;
        exp_t e;

        timed_out = 1'b0;
        rst = 1'b1;
        bus.mem_read = 1'b0;  bus.mem_write = 1'b0;  bus.lru_way = '0;  bus.pmem_resp = 1'b0;
        bus2.mem_read = 1'b0; bus2.mem_write = 1'b0; bus2.lru_way = '0; bus2.pmem_resp = 1'b0;
        bus2.l2_state = 16'h0100;
        req_tag = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            dp_tag[i] = '0; dp_valid[i] = 1'b0; dp_dirty[i] = 1'b0;
            g_tag[i]  = '0; g_valid[i]  = 1'b0; g_dirty[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", {bus.l2_ctl, bus.mem_resp, bus.data_in_sel, bus.pmem_addr_sel,
                           bus.pmem_read, bus.pmem_write}, 64'd0);
        chk("reset_cnt", {32'd0, hit_count, miss_count}, 64'd0);

        mon_en  = 1'b1;
        resp_en = 1'b1;

        // Random traffic on a small tag range so hits, clean and dirty misses all occur
        for (int n = 0; n < NTX && !timed_out; n++) begin
            @(posedge clk);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            t    = $urandom_range(0, 11);
            wr   = 1'($urandom_range(0, 1));
            both = ($urandom_range(0, 5) == 0);
            v    = $urandom_range(0, 7);
            hit  = 1'b0;
            w    = 0;
            for (int i = 0; i < 8; i++) begin
                if (!hit && g_valid[i] && g_tag[i] == 8'(t)) begin
                    hit = 1'b1;
                    w   = i;
                end
            end
            e.wr   = wr;
            e.miss = !hit;
            e.wb   = !hit && g_dirty[v];
            e.way  = hit ? 3'(w) : 3'(v);
            if (!hit) begin
                g_tag[v]   = 8'(t);
                g_valid[v] = 1'b1;
                g_dirty[v] = 1'b0;
                exp_misses++;
            end
            if (wr) g_dirty[e.way] = 1'b1;
            exp_hits++;
            exp_q.push_back(e);

            req_tag       = 8'(t);
            bus.lru_way   = 3'(v);
            bus.mem_write = wr;
            bus.mem_read  = !wr || both;

            start = resp_cnt;
            cyc   = 0;
            while (resp_cnt == start && cyc < 200) begin
                @(posedge clk);
                cyc++;
            end
            #1;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            if (resp_cnt == start) begin
                checks++;
                errors++;
                timed_out = 1'b1;
                $display("FAIL timeout: no mem_resp for request %0d, got 0 responses, expected 1", n);
            end else begin
                logic [23:0] dp_s;
                logic [23:0] g_s;
                for (int i = 0; i < 8; i++) begin
                    dp_s[3*i +: 3] = {dp_valid[i], dp_dirty[i], dp_valid[i] && dp_tag[i] == g_tag[i]};
                    g_s[3*i +: 3]  = {g_valid[i], g_dirty[i], g_valid[i]};
                end
                chk("tag_store", 64'(dp_s), 64'(g_s));
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hit_count", 64'(hit_count), 64'(exp_hits));
        chk("miss_count", 64'(miss_count), 64'(exp_misses));

        // Reset while a dirty writeback is outstanding
        mon_en  = 1'b0;
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        dp_valid[7] = 1'b1; dp_tag[7] = 8'd200; dp_dirty[7] = 1'b1;
        req_tag       = 8'd201;
        bus.lru_way   = 3'd7;
        bus.mem_write = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pre_wb", {62'd0, bus.pmem_write, bus.pmem_addr_sel}, 64'd3);
        @(posedge clk);
        #1 rst = 1'b1; bus.mem_write = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pmem", {62'd0, bus.pmem_read, bus.pmem_write}, 64'd0);
        chk("rst_cnt", {32'd0, hit_count, miss_count}, 64'd0);
        @(posedge clk);
        #1 bus.pmem_resp = 1'b1;
        @(negedge clk);
        chk("stray_resp", {bus.l2_ctl, bus.mem_resp, bus.pmem_read, bus.pmem_write}, 64'd0);
        @(posedge clk);
        #1 bus.pmem_resp = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {bus.l2_ctl, bus.pmem_read, bus.pmem_write}, 64'd0);

        // Saturation: five back-to-back read hits on way3 with a 2-bit counter
        @(posedge clk);
        #1 bus2.mem_read = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("sat_resp", {22'd0, bus2.l2_ctl, bus2.mem_resp}, {22'd0, 41'h100_0000_0000, 1'b1});
            chk("sat_progress", 64'(hit_count2), 64'((k < 3) ? k : 3));
        end
        @(posedge clk);
        #1 bus2.mem_read = 1'b0;
        @(negedge clk);
        chk("sat_hold", 64'(hit_count2), 64'd3);
        @(negedge clk);
        chk("sat_stay", {62'd0, hit_count2}, 64'd3);
        chk("sat_miss", 64'(miss_count2), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- Control FSM for the 8-way unified L2 cache; sits between the L1 arbiter (upstream) and physical memory (downstream).
- Consumes per-way hit/dirty status (lc3b_L2_state) from the L2 datapath.
- Produces the per-way load/valid/dirty strobes and the LRU update (lc3b_L2_ctl) that the datapath consumes.
- Handles hits, clean-miss fills and dirty-victim writebacks, and keeps saturating hit/miss counters.

Parameters:
- CNT_W, 16, width of the hit and miss performance counters.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  upstream read request, held until mem_resp
- mem_write  in  1  upstream write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to upstream
- l2_state  in  16  lc3b_L2_state; way0 in bits [15:14] as {d_out,hit}, way7 in [1:0]
- lru_way  in  3  victim way index from the datapath LRU for the addressed set
- l2_ctl  out  41  lc3b_L2_ctl; load_lru is bit 40; way0 is [39:35] as {load_d,load_v,load_TD,d_in,v_in}; way7 is [4:0]
- data_in_sel  out  1  0 = way data from upstream write, 1 = from pmem line
- pmem_addr_sel  out  1  0 = request tag/index, 1 = victim tag/index
- pmem_read  out  1  physical memory line read
- pmem_write  out  1  physical memory line write
- pmem_resp  in  1  physical memory completion pulse
- hit_count  out  CNT_W  saturating count of hit completions
- miss_count  out  CNT_W  saturating count of misses entered

Behaviour:
- States: IDLE, WRITEBACK, FILL. Reset gives IDLE, counters 0 and all outputs 0.
- Outputs are combinational from the state and inputs. With no request in IDLE, every output bit is 0.
- req = mem_read | mem_write. If both are high, the access is handled as a write.
- hit = OR of all way.hit bits. hit_way = lowest-index way with hit=1; multiple hits are a datapath error, and lowest index wins.
- IDLE, req and hit, same cycle:
  - mem_resp=1, load_lru=1. Stay IDLE. hit_count increments.
  - On a write, additionally for hit_way: load_TD=1, load_d=1, d_in=1, and data_in_sel=0.
  - A read drives no way strobes.
- IDLE, req and no hit:
  - miss_count increments.
  - Next state is WRITEBACK if way[lru_way].d_out=1, else FILL.
  - No mem_resp.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1. Hold until pmem_resp=1, then go to FILL.
- FILL: pmem_read=1, pmem_addr_sel=0.
  - On pmem_resp, for way lru_way: load_TD=1, load_v=1, v_in=1, load_d=1, d_in=0, and data_in_sel=1. Then go to IDLE.
  - The request, still held, hits on the next cycle and completes through the normal hit path.
  - Latency: hit = 0 cycles after the request is seen; clean miss = fill + 1; dirty miss = writeback + fill + 1.
- lru_way is sampled combinationally in every state. The datapath guarantees it is stable while a miss is in progress; the FSM does not latch it.
- pmem_resp outside WRITEBACK/FILL is ignored.
- Upstream must hold req and the address until mem_resp. If req drops mid-miss, the in-flight WRITEBACK/FILL still completes and the FSM returns to IDLE with no mem_resp.
- Counters saturate at 2^CNT_W-1; they never wrap.
- rst asserted in any state: the next edge gives IDLE and zero counters, and pmem_read/pmem_write deassert in the cycle after that edge.
- Way strobes are asserted only for the single selected way; the other seven ways' fields are 0.

Test Plan:
- Read hit, way3: l2_state hit bit for way3=1, mem_read=1 -> same cycle mem_resp=1, load_lru=1, all way strobes 0, hit_count 0->1.
- Write hit, way5: mem_write=1, way5 hit -> same cycle way5 {load_d,load_v,load_TD,d_in,v_in}=5'b10110, data_in_sel=0, mem_resp=1.
- Clean miss: mem_read=1, no hits, lru_way=2, way2 d_out=0 -> FILL, pmem_read=1 held 4 cycles; pmem_resp gives way2 strobes 5'b11101 and data_in_sel=1; set way2 hit next cycle -> mem_resp; miss_count=1.
- Dirty miss: lru_way=7 with d_out=1 -> WRITEBACK with pmem_write=1, pmem_addr_sel=1; pmem_resp -> FILL with pmem_read=1, pmem_addr_sel=0; then fill and hit as above; exactly one mem_resp total.
- Reset mid-WRITEBACK: rst=1 for 1 cycle -> IDLE, pmem_write=0, counters 0; a later pmem_resp pulse causes no way strobes.
- Saturation with CNT_W=2: 5 read hits -> hit_count=3 and stays 3.
